fifo_rd_stream: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_stream_if.sv | 28 ++
 rtl/fifo_rd_skid.sv | 50 +++++
 rtl/fifo_rd_stream.sv | 93 +++++++++
 tb/tb_fifo_rd_stream.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream consumer: word type,
// pointer width of the default buffer and the FSM state encoding.
package fifo_pkg;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 2;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of the
// read-side consumer. The consumer side uses master, the environment slave.
interface fifo_rd_stream_if;
  import fifo_pkg::*;

  logic  empty;
  word_t fifo_dout;
  logic  r_en;

  // A read is accepted on an edge where r_en & !empty; fifo_dout is valid
  // the following cycle. A stream word moves on an edge where
  // m_valid & m_ready; while m_valid & !m_ready, m_data/m_last hold still.
  word_t m_data;
  logic  m_valid;
  logic  m_ready;
  logic  m_last;

  modport master (
    input  empty, fifo_dout, m_ready,
    output r_en, m_data, m_valid, m_last
  );

  modport slave (
    output empty, fifo_dout, m_ready,
    input  r_en, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Circular output buffer: captures FIFO read data, presents the oldest
// entry at head and tracks occupancy. Callers never push when full.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  word_t            din,
  output word_t            head,
  output logic [OCC_W-1:0] occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entries are zeroed at reset so the idle head reads as 0.
  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: issues r_en, absorbs the one-cycle read latency
// into a small buffer and presents a framed valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter  int BUF_DEPTH = 3,
  parameter  int PKT_LEN   = 8,
  parameter  int CNT_W     = 16,
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                en,
  fifo_rd_stream_if.master    bus,
  output logic [CNT_W-1:0]    rd_count,
  output logic                busy,
  output rd_state_e           dbg_state,
  output logic [OCC_W-1:0]    dbg_occ,
  output logic                dbg_inflight
);

  localparam logic [OCC_W:0] DEPTH_L  = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [7:0]     LAST_IDX = 8'(PKT_LEN - 1);

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic             inflight;
  logic             accept;
  logic             pop;
  logic             room;
  logic [7:0]       pkt_cnt;
  logic [OCC_W-1:0] occ;
  word_t            head;

  // Room counts the word already in flight, so r_en never needs m_ready.
  assign room     = ({1'b0, occ} + {{OCC_W{1'b0}}, inflight}) < DEPTH_L;
  assign bus.r_en = (state == STREAM) && !bus.empty && room;
  assign accept   = bus.r_en && !bus.empty;

  assign bus.m_valid = (occ != '0);
  assign pop         = bus.m_valid && bus.m_ready;
  assign bus.m_data  = head;
  assign bus.m_last  = bus.m_valid && (pkt_cnt == LAST_IDX);

  fifo_rd_skid #(
    .DEPTH (BUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_skid (
    .rclk (rclk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (bus.fifo_dout),
    .head (head),
    .occ  (occ)
  );

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = STREAM;
      STREAM:  if (!en) state_nxt = FLUSH;
      FLUSH: begin
        if (en)                               state_nxt = STREAM;
        else if (!inflight && (occ == '0))    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      pkt_cnt  <= 8'd0;
      rd_count <= '0;
    end else begin
      inflight <= accept;
      if (inflight) rd_count <= rd_count + 1'b1;
      if (pop) pkt_cnt <= (pkt_cnt == LAST_IDX) ? 8'd0 : pkt_cnt + 8'd1;
    end
  end

  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign dbg_occ      = occ;
  assign dbg_inflight = inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a FIFO model feeding the read port, a stream
// monitor, and per-scenario tasks checking against accepted-word queues.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int PKT_LEN   = 8;
  localparam int BUF_DEPTH = 3;

  logic        rclk;
  logic        rst;
  logic        en;
  logic [15:0] rd_count;
  logic        busy;
  rd_state_e   dbg_state;
  logic [1:0]  dbg_occ;
  logic        dbg_inflight;

  fifo_rd_stream_if bus ();

  fifo_rd_stream #(
    .BUF_DEPTH (BUF_DEPTH),
    .PKT_LEN   (PKT_LEN),
    .CNT_W     (16)
  ) dut (
    .rclk         (rclk),
    .rst          (rst),
    .en           (en),
    .bus          (bus),
    .rd_count     (rd_count),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_occ      (dbg_occ),
    .dbg_inflight (dbg_inflight)
  );

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // ---------------- shared model state ----------------
  logic [DATA_W-1:0] wq[$];      // words waiting in the FIFO
  logic [DATA_W-1:0] exp_q[$];   // words the FIFO handed out since reset
  int                acc_t[$];
  int                acc_cnt;
  bit                acc_now;
  bit                toggle_mode;
  word_t             got_d[$];
  logic              got_l[$];
  int                got_t[$];
  int                cyc;
  int                hold_viol;
  int                total;
  int                bad;

  // FIFO model: decides acceptance half a cycle before the edge, drives
  // read data during the following cycle.
  initial begin : fifo_model
    bit    pend;
    bit    tog;
    word_t pend_word;
    bus.empty     = 1'b1;
    bus.fifo_dout = '0;
    pend = 0; tog = 0; acc_cnt = 0; acc_now = 0;
    forever begin
      @(negedge rclk);
      if (!rst) begin
        pend = 0;
        exp_q.delete();
        acc_t.delete();
        acc_cnt = 0;
      end
      if (pend) begin
        bus.fifo_dout = pend_word;
        pend = 0;
      end
      tog = !tog;
      bus.empty = (wq.size() == 0) || (toggle_mode && tog);
      #1;
      acc_now = 0;
      if (rst && bus.r_en && !bus.empty) begin
        pend_word = wq.pop_front();
        pend = 1;
        exp_q.push_back(pend_word);
        acc_t.push_back(cyc);
        acc_cnt++;
        acc_now = 1;
      end
    end
  end

  // Stream monitor: records every transfer and any change while stalled.
  initial begin : stream_monitor
    bit    hold;
    word_t hold_d;
    logic  hold_l;
    cyc = 0; hold = 0; hold_viol = 0;
    forever begin
      @(negedge rclk);
      cyc++;
      if (!rst) begin
        got_d.delete(); got_l.delete(); got_t.delete();
        hold = 0;
        hold_viol = 0;
      end else begin
        if (hold && (bus.m_valid !== 1'b1 || bus.m_data !== hold_d || bus.m_last !== hold_l))
          hold_viol++;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
          got_d.push_back(bus.m_data);
          got_l.push_back(bus.m_last);
          got_t.push_back(cyc);
        end
        hold   = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
        hold_d = bus.m_data;
        hold_l = bus.m_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input bit clear_fifo);
    @(posedge rclk); #1;
    rst = 1'b0;
    en = 1'b0;
    bus.m_ready = 1'b0;
    toggle_mode = 1'b0;
    if (clear_fifo) wq.delete();
    repeat (3) @(posedge rclk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load_words(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      wq.push_back(rnd ? word_t'($urandom_range(0, 16383)) : word_t'(i + 1));
  endtask

  // Runs until every accepted word has come out, or the budget expires.
  task automatic wait_drain(input bit rand_ready, output bit ok);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge rclk); #1;
      bus.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ((wq.size() == 0 || !en) && got_d.size() == exp_q.size() && !bus.m_valid) begin
        ok = 1;
        break;
      end
    end
    bus.m_ready = 1'b1;
    repeat (4) @(posedge rclk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge rclk);
    #1;
    total++; if (bus.r_en !== 1'b0)    begin bad++; $display("FAIL rst_r_en got=%b exp=0", bus.r_en); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    total++; if (bus.m_data !== '0)    begin bad++; $display("FAIL rst_m_data got=%0h exp=0", bus.m_data); end
    total++; if (bus.m_last !== 1'b0)  begin bad++; $display("FAIL rst_m_last got=%b exp=0", bus.m_last); end
    total++; if (rd_count !== 16'd0)   begin bad++; $display("FAIL rst_rd_count got=%0d exp=0", rd_count); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (dbg_state !== IDLE)   begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    total++; if (dbg_occ !== 2'd0)     begin bad++; $display("FAIL rst_occ got=%0d exp=0", dbg_occ); end
    total++; if (dbg_inflight !== 1'b0) begin bad++; $display("FAIL rst_inflight got=%b exp=0", dbg_inflight); end
    rst = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    total++; if (busy !== 1'b0 || bus.r_en !== 1'b0) begin bad++; $display("FAIL idle_no_en busy=%b r_en=%b exp=0,0", busy, bus.r_en); end
  endtask

  task automatic test_stream();
    bit ok;
    apply_reset(1);
    load_words(16, 0);
    en = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stream_timeout got=%0d words exp=%0d", got_d.size(), exp_q.size()); end
    total++; if (got_d.size() !== 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 16; k++) begin
      logic exp_l;
      exp_l = ((k % PKT_LEN) == PKT_LEN - 1);
      total++;
      if (got_d[k] !== word_t'(k + 1) || got_l[k] !== exp_l) begin
        bad++; $display("FAIL stream_word[%0d] got=%0h/%b exp=%0h/%b", k, got_d[k], got_l[k], k + 1, exp_l);
      end
    end
    for (int k = 1; k < got_t.size(); k++) begin
      total++; if (got_t[k] - got_t[k-1] !== 1) begin bad++; $display("FAIL stream_rate[%0d] got=%0d cycles exp=1", k, got_t[k] - got_t[k-1]); end
    end
    if (got_t.size() > 0 && acc_t.size() > 0) begin
      total++; if (got_t[0] - acc_t[0] !== 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", got_t[0] - acc_t[0]); end
    end
    total++; if (rd_count !== 16'd16) begin bad++; $display("FAIL stream_rd_count got=%0d exp=16", rd_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset(1);
    bus.m_ready = 1'b0;
    load_words(12, 0);
    en = 1'b1;
    repeat (10) @(posedge rclk);
    #1;
    total++; if (acc_cnt !== BUF_DEPTH) begin bad++; $display("FAIL bp_reads got=%0d exp=%0d", acc_cnt, BUF_DEPTH); end
    total++; if (dbg_occ !== 2'd3)      begin bad++; $display("FAIL bp_occ got=%0d exp=3", dbg_occ); end
    total++; if (bus.r_en !== 1'b0)     begin bad++; $display("FAIL bp_r_en got=%b exp=0", bus.r_en); end
    total++; if (bus.m_valid !== 1'b1 || bus.m_data !== word_t'(1)) begin bad++; $display("FAIL bp_head got=%b/%0h exp=1/1", bus.m_valid, bus.m_data); end
    total++; if (hold_viol !== 0)       begin bad++; $display("FAIL bp_stall_stable got=%0d changes exp=0", hold_viol); end
    wait_drain(1, ok);
    total++; if (!ok || got_d.size() !== 12) begin bad++; $display("FAIL bp_drain got=%0d words exp=12", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      logic exp_l;
      exp_l = ((k % PKT_LEN) == PKT_LEN - 1);
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== exp_l) begin
        bad++; $display("FAIL bp_word[%0d] got=%0h/%b exp=%0h/%b", k, got_d[k], got_l[k], exp_q[k], exp_l);
      end
    end
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL bp_hold got=%0d changes exp=0", hold_viol); end
    total++; if (rd_count !== 16'd12) begin bad++; $display("FAIL bp_rd_count got=%0d exp=12", rd_count); end
  endtask

  task automatic test_empty_toggle();
    bit ok;
    apply_reset(1);
    toggle_mode = 1'b1;
    load_words(24, 1);
    en = 1'b1;
    wait_drain(1, ok);
    total++; if (!ok || got_d.size() !== 24) begin bad++; $display("FAIL tog_drain got=%0d words exp=24", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      logic exp_l;
      exp_l = ((k % PKT_LEN) == PKT_LEN - 1);
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== exp_l) begin
        bad++; $display("FAIL tog_word[%0d] got=%0h/%b exp=%0h/%b", k, got_d[k], got_l[k], exp_q[k], exp_l);
      end
    end
    total++; if (rd_count !== 16'(acc_cnt)) begin bad++; $display("FAIL tog_rd_count got=%0d exp=%0d", rd_count, acc_cnt); end
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL tog_hold got=%0d changes exp=0", hold_viol); end
    toggle_mode = 1'b0;
  endtask

  task automatic test_flush();
    bit ok;
    bit found;
    apply_reset(1);
    load_words(30, 1);
    en = 1'b1;
    bus.m_ready = 1'b1;
    found = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge rclk); #2;
      if (acc_now && n >= 4) begin
        en = 1'b0;
        found = 1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL flush_no_read got=0 exp=1"); end
    @(posedge rclk); #1;
    total++; if (dbg_state !== FLUSH) begin bad++; $display("FAIL flush_state got=%0d exp=%0d", dbg_state, FLUSH); end
    total++; if (dbg_inflight !== 1'b1) begin bad++; $display("FAIL flush_inflight got=%b exp=1", dbg_inflight); end
    total++; if (bus.r_en !== 1'b0) begin bad++; $display("FAIL flush_r_en got=%b exp=0", bus.r_en); end
    wait_drain(1, ok);
    total++; if (!ok || got_d.size() !== exp_q.size()) begin bad++; $display("FAIL flush_drain got=%0d words exp=%0d", got_d.size(), exp_q.size()); end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      logic exp_l;
      exp_l = ((k % PKT_LEN) == PKT_LEN - 1);
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== exp_l) begin
        bad++; $display("FAIL flush_word[%0d] got=%0h/%b exp=%0h/%b", k, got_d[k], got_l[k], exp_q[k], exp_l);
      end
    end
    total++; if (busy !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL flush_idle busy=%b state=%0d exp=0,%0d", busy, dbg_state, IDLE); end
    total++; if (rd_count !== 16'(acc_cnt)) begin bad++; $display("FAIL flush_rd_count got=%0d exp=%0d", rd_count, acc_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int left;
    apply_reset(1);
    load_words(20, 1);
    bus.m_ready = 1'b0;
    en = 1'b1;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge rclk); #1;
      if (dbg_occ == 2'd2 && dbg_inflight) begin
        found = 1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_setup got=%0d/%b exp=2/1", dbg_occ, dbg_inflight); end
    rst = 1'b0;
    #1;
    total++; if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_last !== 1'b0) begin bad++; $display("FAIL mid_stream got=%b/%0h/%b exp=0/0/0", bus.m_valid, bus.m_data, bus.m_last); end
    total++; if (bus.r_en !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL mid_ctrl r_en=%b busy=%b state=%0d exp=0,0,%0d", bus.r_en, busy, dbg_state, IDLE); end
    total++; if (dbg_occ !== 2'd0 || dbg_inflight !== 1'b0 || rd_count !== 16'd0) begin bad++; $display("FAIL mid_regs occ=%0d inflight=%b rd_count=%0d exp=0,0,0", dbg_occ, dbg_inflight, rd_count); end
    en = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    left = wq.size();
    rst = 1'b1;
    en = 1'b1;
    bus.m_ready = 1'b1;
    wait_drain(0, ok);
    total++; if (!ok || got_d.size() !== left) begin bad++; $display("FAIL mid_drain got=%0d words exp=%0d", got_d.size(), left); end
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      logic exp_l;
      exp_l = ((k % PKT_LEN) == PKT_LEN - 1);
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== exp_l) begin
        bad++; $display("FAIL mid_word[%0d] got=%0h/%b exp=%0h/%b", k, got_d[k], got_l[k], exp_q[k], exp_l);
      end
    end
    total++; if (rd_count !== 16'(left)) begin bad++; $display("FAIL mid_rd_count got=%0d exp=%0d", rd_count, left); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    en = 1'b0;
    bus.m_ready = 1'b0;
    toggle_mode = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_toggle();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
